// File: rtl/updown_bcd_counter.sv
// Four-digit BCD up/down counter driven by debounced button levels.
// Rising edges of up_in/down_in each give one step; supports load, wrap or saturation.
module updown_bcd_counter #(
    parameter int unsigned WRAP = 1
) (
    input  logic        clk,
    input  logic        rst_a_p,
    input  logic        up_in,
    input  logic        down_in,
    input  logic        load_en,
    input  logic [15:0] load_bcd,
    output logic [15:0] count_bcd,
    output logic        changed,
    output logic        at_max,
    output logic        at_min
);

    logic        up_prev_q,    up_prev_d;
    logic        down_prev_q,  down_prev_d;
    logic        up_pulse_q,   up_pulse_d;
    logic        down_pulse_q, down_pulse_d;
    logic [15:0] count_q,      count_d;
    logic        changed_q,    changed_d;
    logic        at_max_q,     at_max_d;
    logic        at_min_q,     at_min_d;

    logic [16:0] inc_res;
    logic [16:0] dec_res;

    // Bit 16 of the result flags a carry out of the thousands digit (9999 -> 0000).
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Bit 16 of the result flags a borrow out of the thousands digit (0000 -> 9999).
    function automatic logic [16:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    function automatic logic bcd_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    always_comb begin
        up_prev_d    = up_in;
        down_prev_d  = down_in;
        up_pulse_d   = up_in & ~up_prev_q;
        down_pulse_d = down_in & ~down_prev_q;

        inc_res = bcd_inc(count_q);
        dec_res = bcd_dec(count_q);

        count_d = count_q;
        // A load strobe always consumes the pending pulse, even when the load value is rejected.
        if (load_en) begin
            if (bcd_valid(load_bcd)) begin
                count_d = load_bcd;
            end
        end else if (up_pulse_q && !down_pulse_q) begin
            if (!inc_res[16] || (WRAP != 0)) begin
                count_d = inc_res[15:0];
            end
        end else if (down_pulse_q && !up_pulse_q) begin
            if (!dec_res[16] || (WRAP != 0)) begin
                count_d = dec_res[15:0];
            end
        end

        changed_d = (count_d != count_q);
        at_max_d  = (count_d == 16'h9999);
        at_min_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            up_prev_q    <= 1'b1;
            down_prev_q  <= 1'b1;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
            count_q      <= '0;
            changed_q    <= 1'b0;
            at_max_q     <= 1'b0;
            at_min_q     <= 1'b1;
        end else begin
            up_prev_q    <= up_prev_d;
            down_prev_q  <= down_prev_d;
            up_pulse_q   <= up_pulse_d;
            down_pulse_q <= down_pulse_d;
            count_q      <= count_d;
            changed_q    <= changed_d;
            at_max_q     <= at_max_d;
            at_min_q     <= at_min_d;
        end
    end

    assign count_bcd = count_q;
    assign changed   = changed_q;
    assign at_max    = at_max_q;
    assign at_min    = at_min_q;

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Self-checking bench: WRAP=1 and WRAP=0 instances share stimulus and are
// compared every cycle against an integer-valued reference model.
module tb_updown_bcd_counter;

    logic        clk;
    logic        rst_a_p;
    logic        up_in;
    logic        down_in;
    logic        load_en;
    logic [15:0] load_bcd;

    logic [15:0] cnt_w;
    logic        chg_w, max_w, min_w;
    logic [15:0] cnt_s;
    logic        chg_s, max_s, min_s;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model: index 0 = wrapping, index 1 = saturating.
    int m_cnt [2];
    bit m_chg [2];
    bit m_pend_up, m_pend_dn, m_prev_up, m_prev_dn;

    updown_bcd_counter #(.WRAP(1)) dut_wrap (
        .clk      (clk),
        .rst_a_p  (rst_a_p),
        .up_in    (up_in),
        .down_in  (down_in),
        .load_en  (load_en),
        .load_bcd (load_bcd),
        .count_bcd(cnt_w),
        .changed  (chg_w),
        .at_max   (max_w),
        .at_min   (min_w)
    );

    updown_bcd_counter #(.WRAP(0)) dut_sat (
        .clk      (clk),
        .rst_a_p  (rst_a_p),
        .up_in    (up_in),
        .down_in  (down_in),
        .load_en  (load_en),
        .load_bcd (load_bcd),
        .count_bcd(cnt_s),
        .changed  (chg_s),
        .at_max   (max_s),
        .at_min   (min_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] int_to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v);
        logic [15:0] t;
        bit ok;
        t  = v;
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (t[3:0] > 4'd9) ok = 0;
            t = t >> 4;
        end
        return ok;
    endfunction

    function automatic int bcd_to_int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic model_update(input bit r, input bit u, input bit d, input bit l, input logic [15:0] lv);
        int nxt;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0;
                m_chg[k] = 0;
            end
            m_pend_up = 0;
            m_pend_dn = 0;
            m_prev_up = 1;
            m_prev_dn = 1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                nxt = m_cnt[k];
                if (l) begin
                    if (bcd_ok(lv)) nxt = bcd_to_int(lv);
                end else if (m_pend_up && !m_pend_dn) begin
                    if (m_cnt[k] < 9999) nxt = m_cnt[k] + 1;
                    else if (k == 0)     nxt = 0;
                end else if (m_pend_dn && !m_pend_up) begin
                    if (m_cnt[k] > 0) nxt = m_cnt[k] - 1;
                    else if (k == 0)  nxt = 9999;
                end
                m_chg[k] = (nxt != m_cnt[k]);
                m_cnt[k] = nxt;
            end
            m_pend_up = u && !m_prev_up;
            m_pend_dn = d && !m_prev_dn;
            m_prev_up = u;
            m_prev_dn = d;
        end
    endtask

    task automatic compare_all();
        check("count_wrap",  32'(cnt_w), 32'(int_to_bcd(m_cnt[0])));
        check("changed_wrap", 32'(chg_w), 32'(m_chg[0]));
        check("at_max_wrap",  32'(max_w), 32'(m_cnt[0] == 9999));
        check("at_min_wrap",  32'(min_w), 32'(m_cnt[0] == 0));
        check("count_sat",   32'(cnt_s), 32'(int_to_bcd(m_cnt[1])));
        check("changed_sat",  32'(chg_s), 32'(m_chg[1]));
        check("at_max_sat",   32'(max_s), 32'(m_cnt[1] == 9999));
        check("at_min_sat",   32'(min_s), 32'(m_cnt[1] == 0));
    endtask

    task automatic step(input bit r, input bit u, input bit d, input bit l, input logic [15:0] lv);
        rst_a_p  = r;
        up_in    = u;
        down_in  = d;
        load_en  = l;
        load_bcd = lv;
        @(posedge clk);
        model_update(r, u, d, l, lv);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0000);
    endtask

    task automatic press(input bit u, input bit d);
        step(0, u, d, 0, 16'h0000);
        idle(3);
    endtask

    task automatic load(input logic [15:0] v);
        step(0, 0, 0, 1, v);
        idle(1);
    endtask

    initial begin
        bit          ru, rd;
        logic [15:0] lv;
        int          chg_seen;

        n_checks = 0;
        n_fail   = 0;
        rst_a_p  = 1'b1;
        up_in    = 1'b0;
        down_in  = 1'b0;
        load_en  = 1'b0;
        load_bcd = '0;

        step(1, 0, 0, 0, 16'h0000);
        step(1, 0, 0, 0, 16'h0000);
        check("reset_count", 32'(cnt_w), 32'h0);
        check("reset_at_min", 32'(min_w), 32'h1);
        idle(2);

        // Held press: one step, two edges after the first high sample.
        chg_seen = 0;
        step(0, 1, 0, 0, 16'h0000);
        check("hold_edge1", 32'(cnt_w), 32'h0000);
        step(0, 1, 0, 0, 16'h0000);
        check("hold_edge2", 32'(cnt_w), 32'h0001);
        for (int i = 0; i < 98; i++) begin
            step(0, 1, 0, 0, 16'h0000);
            if (chg_w) chg_seen++;
        end
        check("hold_final", 32'(cnt_w), 32'h0001);
        check("hold_no_more_changed", 32'(chg_seen), 32'd0);
        idle(2);

        load(16'h0099);
        press(1, 0);
        check("carry_0100", 32'(cnt_w), 32'h0100);
        press(0, 1);
        check("borrow_0099", 32'(cnt_w), 32'h0099);

        load(16'h9999);
        press(1, 0);
        check("wrap_up", 32'(cnt_w), 32'h0000);
        check("wrap_up_min", 32'(min_w), 32'h1);
        check("sat_up_hold", 32'(cnt_s), 32'h9999);
        press(0, 1);
        check("wrap_down", 32'(cnt_w), 32'h9999);
        check("wrap_down_max", 32'(max_w), 32'h1);
        check("sat_down", 32'(cnt_s), 32'h9998);

        load(16'h0000);
        press(0, 1);
        check("sat_down_hold", 32'(cnt_s), 32'h0000);

        load(16'h1234);
        press(1, 1);
        check("both_pressed", 32'(cnt_w), 32'h1234);
        load(16'h12A4);
        check("bad_load", 32'(cnt_w), 32'h1234);
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 0, 1, 16'h0500);
        idle(3);
        check("load_over_pulse", 32'(cnt_w), 32'h0500);

        // Button held through reset must be released before it counts again.
        step(0, 1, 0, 0, 16'h0000);
        step(1, 1, 0, 0, 16'h0000);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'h0000);
        check("held_thru_reset", 32'(cnt_w), 32'h0000);
        idle(1);
        press(1, 0);
        check("after_repress", 32'(cnt_w), 32'h0001);

        // Randomised phase.
        ru = 0;
        rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) ru = !ru;
            if ($urandom_range(0, 3) == 0) rd = !rd;
            if ($urandom_range(0, 199) == 0) begin
                step(1, ru, rd, 0, 16'h0000);
            end else if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0:       lv = 16'($urandom);
                    1:       lv = 16'h9999;
                    2:       lv = 16'h0000;
                    default: lv = int_to_bcd(int'($urandom_range(0, 9999)));
                endcase
                step(0, ru, rd, 1, lv);
            end else begin
                step(0, ru, rd, 0, 16'h0000);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_bcd_counter.md
UPDOWN_BCD_COUNTER -- requirements
Module: updown_bcd_counter

Interface
REQ-001 The block SHALL have parameter WRAP, default 1, selecting wrap-around (1) or saturation (0) at the count limits.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_a_p, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port up_in, input, 1 bit: debounced "count up" button level from the upstream debouncer.
REQ-005 The block SHALL have port down_in, input, 1 bit: debounced "count down" button level from the upstream debouncer.
REQ-006 The block SHALL have port load_en, input, 1 bit: synchronous load strobe.
REQ-007 The block SHALL have port load_bcd, input, 16 bits: four BCD digits to load, [15:12] thousands to [3:0] units.
REQ-008 The block SHALL have port count_bcd, output, 16 bits: current count as four BCD digits, same digit order.
REQ-009 The block SHALL have port changed, output, 1 bit: one-cycle pulse when count_bcd changed on the previous edge.
REQ-010 The block SHALL have port at_max, output, 1 bit: high while count_bcd = 9999.
REQ-011 The block SHALL have port at_min, output, 1 bit: high while count_bcd = 0000.

Function
REQ-012 The block SHALL register up_in and down_in into up_prev and down_prev every cycle.
REQ-013 The block SHALL register up_pulse = up_in AND NOT up_prev and down_pulse = down_in AND NOT down_prev, each one cycle wide.
REQ-014 The block SHALL update the count on the edge after a registered pulse, giving 2-cycle latency from the first edge sampling up_in=1 to the new count_bcd.
REQ-015 A level held high SHALL produce exactly one step; stepping again requires a low sample followed by a high sample.
REQ-016 up_pulse alone SHALL increment by one in BCD, with the units digit carrying into tens, tens into hundreds, and hundreds into thousands at digit 9.
REQ-017 down_pulse alone SHALL decrement by one in BCD, with a borrow from the next digit when a digit is 0, that digit becoming 9.
REQ-018 When up_pulse and down_pulse are high in the same cycle, the count SHALL NOT change and changed SHALL NOT pulse.
REQ-019 With WRAP=1, incrementing at 9999 SHALL give 0000 and decrementing at 0000 SHALL give 9999.
REQ-020 With WRAP=0, incrementing at 9999 and decrementing at 0000 SHALL hold the count and SHALL NOT pulse changed.
REQ-021 load_en=1 SHALL load load_bcd on that edge with priority over any pending pulse; that pulse is discarded.
REQ-022 A load whose value contains any digit greater than 9 SHALL be ignored: count unchanged, changed not pulsed.
REQ-023 changed SHALL be high for exactly one cycle following any edge where count_bcd took a different value; loading an equal value SHALL NOT pulse it.
REQ-024 at_max and at_min SHALL be registered, valid in the same cycle as the count_bcd value they describe.

Reset
REQ-025 On an edge with rst_a_p=1: count_bcd=0000, changed=0, at_min=1, at_max=0, up_pulse=down_pulse=0.
REQ-026 On the same edge, up_prev and down_prev SHALL be set to 1, so a button held through reset produces no step.
REQ-027 Reset SHALL have priority over load_en and pulses; a pulse pending on the reset edge is discarded.
REQ-028 Deassertion mid-press SHALL require a release and re-press before the next step.

Verification
REQ-029 Reset, then up_in 0->1 held 100 cycles -> count_bcd=0001 exactly 2 edges after the first high sample; changed pulses once; no further steps.
REQ-030 Load 0x0099, then one up press -> 0x0100; one down press -> 0x0099.
REQ-031 WRAP=1: load 0x9999 and press up -> 0x0000 with at_min=1; then press down -> 0x9999 with at_max=1.
REQ-032 WRAP=0: at 0x9999, press up -> count held, changed stays 0.
REQ-033 up_in and down_in rise on the same cycle -> count unchanged; load 0x12A4 -> ignored; load_en on the pulse cycle with 0x0500 -> 0x0500.
REQ-034 up_in held high through reset, then reset deasserted -> count stays 0000 until up_in goes low and high again.
